// File: rtl/gpc_sum_accum_if.sv
// Sample stream in, frame-total stream out, bundled for gpc_sum_accum.
// The slave side is the accumulator and the master side is the producer/consumer pair.
interface gpc_sum_accum_if #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/gpc_sum_accum.sv
// Saturating frame accumulator for GPC results; the total is registered 1 cycle after the closing sample.
// in_ready = !out_valid | out_ready, so input stalls while a finished frame waits to be consumed.
module gpc_sum_accum #(
  parameter int IN_W      = 3,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  gpc_sum_accum_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0] r_out_sum, w_out_sum_nxt;
  logic [CNT_W-1:0] r_out_count, w_out_count_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_fire;
  logic             w_close;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_sat;
  logic [ACC_W-1:0] w_res;

  assign w_in_ready = !r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_fire     = r_out_valid & bus.out_ready;
  assign w_close    = w_accept & (bus.in_last | (r_cnt == CNT_W'(FRAME_LEN - 1)));

  // One extra bit catches the carry that signals saturation.
  assign w_sum_ext  = {1'b0, r_acc} + (ACC_W + 1)'(bus.in_data);
  assign w_sat      = w_sum_ext[ACC_W];
  assign w_res      = w_sat ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;

    case (r_state)
      S_IDLE, S_ACCUM: ;
      S_DONE: begin
        if (w_fire) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // In DONE an accept implies out_fire, and acc is already clear, so a new frame starts here too.
    if (w_accept) begin
      if (w_close) begin
        w_state_nxt     = S_DONE;
        w_out_valid_nxt = 1'b1;
        w_out_sum_nxt   = w_res;
        w_out_count_nxt = r_cnt + 1'b1;
        w_out_ovf_nxt   = r_ovf | w_sat;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_nxt       = 1'b0;
      end else begin
        w_state_nxt     = S_ACCUM;
        w_acc_nxt       = w_res;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_ovf_nxt       = r_ovf | w_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_gpc_sum_accum.sv
// Three configurations (default, ACC_W=4/FRAME_LEN=4, FRAME_LEN=1) share one stimulus stream;
// each is checked every cycle against a frame-level model plus hand-computed frame totals.
module tb_gpc_sum_accum;

  logic       clk;
  logic       s_rst;
  logic       s_vld;
  logic [2:0] s_dat;
  logic       s_last;
  logic       s_ordy;
  bit         chk_en;

  int n_vec;
  int n_err;

  gpc_sum_accum_if #(.IN_W(3), .ACC_W(16), .CNT_W(8)) if_a ();
  gpc_sum_accum_if #(.IN_W(3), .ACC_W(4),  .CNT_W(8)) if_b ();
  gpc_sum_accum_if #(.IN_W(3), .ACC_W(16), .CNT_W(8)) if_c ();

  gpc_sum_accum #(.IN_W(3), .ACC_W(16), .FRAME_LEN(8), .CNT_W(8)) u_a (.clk(clk), .rst(s_rst), .bus(if_a));
  gpc_sum_accum #(.IN_W(3), .ACC_W(4),  .FRAME_LEN(4), .CNT_W(8)) u_b (.clk(clk), .rst(s_rst), .bus(if_b));
  gpc_sum_accum #(.IN_W(3), .ACC_W(16), .FRAME_LEN(1), .CNT_W(8)) u_c (.clk(clk), .rst(s_rst), .bus(if_c));

  assign if_a.in_valid = s_vld;  assign if_a.in_data = s_dat;  assign if_a.in_last = s_last;  assign if_a.out_ready = s_ordy;
  assign if_b.in_valid = s_vld;  assign if_b.in_data = s_dat;  assign if_b.in_last = s_last;  assign if_b.out_ready = s_ordy;
  assign if_c.in_valid = s_vld;  assign if_c.in_data = s_dat;  assign if_c.in_last = s_last;  assign if_c.out_ready = s_ordy;

  logic        d_vld [3];
  logic        d_rdy [3];
  logic        d_ovf [3];
  logic [15:0] d_sum [3];
  logic [7:0]  d_cnt [3];

  assign d_vld[0] = if_a.out_valid;  assign d_rdy[0] = if_a.in_ready;  assign d_ovf[0] = if_a.out_ovf;
  assign d_vld[1] = if_b.out_valid;  assign d_rdy[1] = if_b.in_ready;  assign d_ovf[1] = if_b.out_ovf;
  assign d_vld[2] = if_c.out_valid;  assign d_rdy[2] = if_c.in_ready;  assign d_ovf[2] = if_c.out_ovf;
  assign d_sum[0] = if_a.out_sum;    assign d_sum[1] = {12'd0, if_b.out_sum};  assign d_sum[2] = if_c.out_sum;
  assign d_cnt[0] = if_a.out_count;  assign d_cnt[1] = if_b.out_count;  assign d_cnt[2] = if_c.out_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: running total, sample count and sticky overflow per instance.
  int AW [3] = '{16, 4, 16};
  int FL [3] = '{8, 4, 1};
  int m_acc [3];
  int m_cnt [3];
  bit m_ovf [3];
  bit e_vld [3];
  int e_sum [3];
  int e_cnt [3];
  bit e_ovf [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      e_vld[k] = 0; e_sum[k] = 0; e_cnt[k] = 0; e_ovf[k] = 0;
    end
  end

  always @(posedge clk) begin : model
    bit rdy, o;
    int s, mx;
    for (int k = 0; k < 3; k++) begin
      if (s_rst) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        e_vld[k] = 0; e_sum[k] = 0; e_cnt[k] = 0; e_ovf[k] = 0;
      end else begin
        rdy = !e_vld[k] || s_ordy;
        if (e_vld[k] && s_ordy) e_vld[k] = 0;
        if (s_vld && rdy) begin
          mx = (1 << AW[k]) - 1;
          s  = m_acc[k] + int'(s_dat);
          o  = (s > mx);
          if (o) s = mx;
          if (s_last || (m_cnt[k] + 1 == FL[k])) begin
            e_vld[k] = 1; e_sum[k] = s; e_cnt[k] = m_cnt[k] + 1; e_ovf[k] = m_ovf[k] | o;
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
          end else begin
            m_acc[k] = s; m_cnt[k] = m_cnt[k] + 1; m_ovf[k] = m_ovf[k] | o;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s inst%0d got=%0d expected=%0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready", k, longint'(d_rdy[k]), longint'(!e_vld[k] || s_ordy));
        chk("out_valid", k, longint'(d_vld[k]), longint'(e_vld[k]));
        if (e_vld[k]) begin
          chk("out_sum", k, longint'(d_sum[k]), longint'(e_sum[k]));
          chk("out_count", k, longint'(d_cnt[k]), longint'(e_cnt[k]));
          chk("out_ovf", k, longint'(d_ovf[k]), longint'(e_ovf[k]));
        end
      end
    end
  end

  // Inputs are applied for the next rising edge; returns 2 time units after that edge.
  task automatic drive(input bit v, input int d, input bit l, input bit r);
    s_vld = v; s_dat = 3'(d); s_last = l; s_ordy = r;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    drive(0, 0, 0, 1);
    s_rst = 1'b0;
  endtask

  task automatic chk_frame(input string nm, input int k, input int sum, input int cnt, input bit ovf);
    chk({nm, "_vld"}, k, longint'(d_vld[k]), 1);
    chk({nm, "_sum"}, k, longint'(d_sum[k]), longint'(sum));
    chk({nm, "_cnt"}, k, longint'(d_cnt[k]), longint'(cnt));
    chk({nm, "_ovf"}, k, longint'(d_ovf[k]), longint'(ovf));
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 3; k++) chk({nm, "_vld"}, k, longint'(d_vld[k]), 0);
    chk({nm, "_sum"}, 0, longint'(d_sum[0]), 0);
    chk({nm, "_cnt"}, 0, longint'(d_cnt[0]), 0);
    chk({nm, "_ovf"}, 0, longint'(d_ovf[0]), 0);
  endtask

  int t1 [8] = '{4, 4, 2, 1, 3, 5, 6, 3};

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    s_rst = 1'b1; s_vld = 0; s_dat = 0; s_last = 0; s_ordy = 1;
    @(posedge clk); #2;
    s_rst = 1'b0;
    chk_zero("reset");
    chk_en = 1;

    // 8 back-to-back samples, total 28.
    for (int i = 0; i < 8; i++) drive(1, t1[i], 0, 1);
    chk_frame("t1", 0, 28, 8, 0);
    drive(0, 0, 0, 1);
    chk("t1_drop", 0, longint'(d_vld[0]), 0);

    // Early in_last, then a full frame of 7s.
    do_reset();
    drive(1, 6, 0, 1); drive(1, 5, 0, 1); drive(1, 1, 1, 1);
    chk_frame("t2a", 0, 12, 3, 0);
    for (int i = 0; i < 8; i++) drive(1, 7, 0, 1);
    chk_frame("t2b", 0, 56, 8, 0);

    // Output backpressure, then consume and start the next frame in one cycle.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      chk("t3_stall_rdy", 0, longint'(d_rdy[0]), 0);
      chk_frame("t3_hold", 0, 8, 8, 0);
    end
    drive(1, 2, 0, 1);
    chk("t3_consumed", 0, longint'(d_vld[0]), 0);
    for (int i = 0; i < 7; i++) drive(1, 1, 0, 1);
    chk_frame("t3_next", 0, 9, 8, 0);

    // Saturation in the 4-bit instance, ovf cleared by the following frame.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 7, 0, 1);
    chk_frame("t4_sat", 1, 15, 4, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
    chk_frame("t4_clr", 1, 4, 4, 0);

    // Reset mid-frame and reset with a pending frame.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 3, 0, 1);
    do_reset();
    chk_zero("t5_mid");
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 1);
    chk_frame("t5_a", 0, 8, 8, 0);
    s_rst = 1'b1; drive(0, 0, 0, 0); s_rst = 1'b0;
    chk_zero("t5_pend");
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 1);
    chk_frame("t5_b", 0, 8, 8, 0);

    // FRAME_LEN=1: every accepted sample is its own frame.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, i, 0, 1);
      chk_frame("t6", 2, i, 1, 0);
    end
    drive(0, 0, 0, 1);
    chk("t6_drop", 2, longint'(d_vld[2]), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end
    s_rst = 1'b0;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
